// File: rtl/lfsr_gen.sv
// Programmable Fibonacci XNOR LFSR pattern generator with valid/ready output,
// stop/limit/lock-up termination and a small config register file.
module lfsr_gen #(
  parameter int unsigned     WIDTH        = 24,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(24'h001008)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             config_rdy_i,
  input  logic [1:0]       config_sel_i,
  input  logic [WIDTH-1:0] config_data_i,
  output logic             config_done_o,
  output logic [WIDTH-1:0] config_data_o,
  input  logic             lfsr_en_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             lfsr_valid_o,
  input  logic             lfsr_ready_i,
  output logic             lfsr_done_o,
  output logic             lockup_o,
  output logic [WIDTH-1:0] count_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q, stop_q, taps_q, limit_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             lockup_q, lockup_d;
  logic             cfg_wr_q, cfg_done_q;

  logic             cfg_accept;
  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] count_inc;
  logic             fixed_point;

  assign cfg_accept  = config_rdy_i && (state_q != StRun);
  assign fb          = ~^(lfsr_q & taps_q);
  assign lfsr_next   = {lfsr_q[WIDTH-2:0], fb};
  assign count_inc   = count_q + WIDTH'(1);
  // All-ones seed with an even number of taps maps to itself under XNOR feedback.
  assign fixed_point = (&seed_q) && !(^taps_q);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    lockup_d = lockup_q;
    unique case (state_q)
      StIdle: begin
        lfsr_d   = seed_q;
        count_d  = '0;
        lockup_d = 1'b0;
        if (lfsr_en_i) begin
          if (fixed_point) begin
            state_d  = StDone;
            lockup_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!lfsr_en_i) begin
          state_d = StIdle;
        end else if (lfsr_ready_i) begin
          lfsr_d  = lfsr_next;
          count_d = count_inc;
          if ((lfsr_next == stop_q) || ((limit_q != '0) && (count_inc == limit_q))) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!lfsr_en_i) begin
          state_d  = StIdle;
          lockup_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      lfsr_q   <= '0;
      count_q  <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
      lockup_q <= lockup_d;
    end
  end

  // Acknowledge trails the register update by one edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      seed_q     <= '0;
      stop_q     <= '0;
      taps_q     <= DEFAULT_TAPS;
      limit_q    <= '0;
      cfg_wr_q   <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_wr_q   <= cfg_accept;
      cfg_done_q <= cfg_wr_q;
      if (cfg_accept) begin
        unique case (config_sel_i)
          2'd0: seed_q  <= config_data_i;
          2'd1: stop_q  <= config_data_i;
          2'd2: taps_q  <= config_data_i;
          2'd3: limit_q <= config_data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    config_data_o = '0;
    unique case (config_sel_i)
      2'd0: config_data_o = seed_q;
      2'd1: config_data_o = stop_q;
      2'd2: config_data_o = taps_q;
      2'd3: config_data_o = limit_q;
      default: config_data_o = '0;
    endcase
  end

  assign config_done_o = cfg_done_q;
  assign lfsr_o        = lfsr_q;
  assign lfsr_valid_o  = (state_q == StRun);
  assign lfsr_done_o   = (state_q == StDone);
  assign lockup_o      = lockup_q;
  assign count_o       = count_q;

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random pixel/test-pattern generator: a WIDTH-bit Fibonacci LFSR with a run-time programmable tap mask, seed, stop value and length limit. It streams values to downstream pixel logic over a valid/ready handshake, with backpressure. It terminates on a stop-value match, a length limit, or lock-up detection. It is the next-generation replacement for the fixed-tap 24-bit generator used by the gray/Sobel test path.

## Interface
- WIDTH, 24: LFSR, seed, stop, tap and counter width (≥4)
- DEFAULT_TAPS, 24'h001008: tap mask loaded at reset (bits 12 and 3)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset; one clock domain
- config_rdy_i  in  1  config write strobe
- config_sel_i  in  2  register select: 0 seed, 1 stop, 2 taps, 3 limit
- config_data_i  in  WIDTH  write data
- config_done_o  out  1  registered acknowledge of an accepted write
- config_data_o  out  WIDTH  combinational readback of the register chosen by config_sel_i
- lfsr_en_i  in  1  level enable; low returns the block to IDLE
- lfsr_o  out  WIDTH  current LFSR state (registered)
- lfsr_valid_o  out  1  lfsr_o is offered
- lfsr_ready_i  in  1  consumer accepts lfsr_o
- lfsr_done_o  out  1  generation finished (stop, limit or lock-up)
- lockup_o  out  1  run refused because seed is the XNOR fixed point
- count_o  out  WIDTH  number of accepted transfers in the current run

## Operation
- Feedback: fb = ~^(state & taps), which is an XNOR reduction. Next state = {state[WIDTH-2:0], fb}.
- States: IDLE, RUN, DONE.
- **IDLE**
  - state ← seed every cycle, count ← 0, valid = 0, done = 0.
  - When lfsr_en_i = 1: if seed == all-ones and the popcount of taps is even (fixed point), go to DONE and set lockup_o = 1. Otherwise go to RUN.
- **RUN**
  - valid = 1 and lfsr_o = state.
  - On valid & ready: state ← next and count ← count+1.
  - After an advance, go to DONE if next == stop, or if limit ≠ 0 and count+1 == limit. Both conditions are evaluated on the same edge; either one is sufficient.
  - Without ready, state and count hold.
  - The seed itself is never compared against stop, so seed == stop runs a full period.
- **DONE**
  - valid = 0, done = 1.
  - lfsr_o, count_o and lockup_o are held.
- Any state with lfsr_en_i = 0: go to IDLE on the next edge, which clears done and lockup. An abort in RUN discards the offered value.
- Config writes:
  - A write is accepted when config_rdy_i = 1 and the state is not RUN. The selected register then updates on that edge, and config_done_o pulses for one cycle on the following edge.
  - Writes in RUN are ignored and produce no config_done_o.
  - Limit 0 means unlimited.
- Counter: WIDTH bits, wraps modulo 2^WIDTH with no flag. It matters only with limit 0.

## Timing
- Reset (async assert, sync deassert by the integrator) drives:
  - seed = 0, stop = 0, taps = DEFAULT_TAPS, limit = 0
  - state IDLE, lfsr_o = 0, count_o = 0
  - all 1-bit outputs = 0
- lfsr_en_i sampled high at edge N gives lfsr_valid_o = 1, with lfsr_o = seed, after edge N. A seed write at edge N-1 is used.
- Throughput: one value per cycle with ready held high. A handshake at edge M shows the new lfsr_o after M.
- Terminating handshake at edge M: after M, lfsr_done_o = 1, lfsr_valid_o = 0, and lfsr_o = the terminating value (never offered).
- Lock-up: lfsr_done_o = lockup_o = 1 one edge after enable; valid never asserts.
- config_done_o: one cycle after the write edge, for one cycle. Back-to-back strobes give back-to-back pulses.
- Simultaneous lfsr_en_i rise and config write in IDLE: the write lands on the same edge the state leaves IDLE. The transition uses the old seed, which is loaded into state in IDLE. The write is still acknowledged.
- Reset mid-RUN: outputs drop immediately to reset values, and config registers revert.

## Test plan
- Stop match:
  - Stimulus: reset; taps = 0x001008, seed = 0, stop = 0x00001E; enable with ready = 1.
  - Response: values 0x000000, 0x000001, 0x000003, 0x000007, 0x00000F accepted; then done = 1, lfsr_o = 0x00001E, count_o = 5.
- Length limit:
  - Stimulus: as the stop-match case, but stop = 0xABCDEF and limit = 3.
  - Response: 0x0, 0x1, 0x3 accepted; then done, lfsr_o = 0x000007, count_o = 3.
- Backpressure:
  - Stimulus: toggle ready pseudo-randomly.
  - Response: the sequence of accepted values and the final count are identical to the stop-match case. lfsr_o holds while valid & !ready.
- Lock-up:
  - Stimulus: seed = 0xFFFFFF with default taps; enable.
  - Response: valid never rises; done = lockup = 1 one cycle after enable. Dropping enable clears both next cycle.
- Config rules:
  - Stimulus: write taps in IDLE, then read back; write stop in RUN.
  - Response: readback equals the written data, with config_done_o pulsing 1 cycle after the write. The RUN write is ignored, with no config_done_o, and the stop readback is unchanged.
- Abort and reset:
  - Stimulus: drop enable after 2 transfers, re-enable; then assert reset_i mid-RUN.
  - Response: after re-enable the sequence restarts at the seed with count_o = 0. On reset, all outputs are 0 asynchronously and taps read back 0x001008.
